conv3x3_column_pe: RTL and testbench



---
 rtl/conv3x3_column_pe_pkg.sv | 22 ++
 rtl/conv3x3_column_pe_mac9.sv | 36 +++
 rtl/conv3x3_column_pe.sv | 245 ++++++++++++++++++++++++
 tb/tb_conv3x3_column_pe.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv3x3_column_pe_pkg.sv
// Shared widths, FSM state type and pixel-slice helper for the 3x3 column PE.
package conv_pe_pkg;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned W_W    = 8;
  localparam int unsigned PROD_W = PIX_W + W_W + 1;
  localparam int unsigned SUM_W  = 21;
  localparam int unsigned N_TAPS = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_DRAIN
  } pe_state_e;

  // MSB of pixel/result idx in a vector of total_w bits, index 0 at the top.
  function automatic int unsigned pix_msb(int unsigned total_w, int unsigned idx);
    return total_w - 1 - PIX_W * idx;
  endfunction

endpackage

// File: rtl/conv3x3_column_pe_mac9.sv
// Nine-tap MAC: unsigned pixels times signed weights, summed into a registered signed sum.
module pe_mac9
  import conv_pe_pkg::*;
(
  input  logic                            PEclk,
  input  logic                            rst_n,
  input  logic                            en_i,
  input  logic [N_TAPS-1:0][PIX_W-1:0]    pix_i,
  input  logic [N_TAPS-1:0][W_W-1:0]      wgt_i,
  output logic [SUM_W-1:0]                sum_o
);

  logic signed [PROD_W-1:0] prod;
  logic signed [SUM_W-1:0]  sum_d;
  logic signed [SUM_W-1:0]  sum_q;

  always_comb begin
    sum_d = '0;
    prod  = '0;
    for (int unsigned k = 0; k < N_TAPS; k++) begin
      prod  = PROD_W'($signed({1'b0, pix_i[k]})) * PROD_W'($signed(wgt_i[k]));
      sum_d = sum_d + SUM_W'(prod);
    end
  end

  always_ff @(posedge PEclk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (en_i) begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/conv3x3_column_pe.sv
// Streaming 3x3 convolution over padded columns with a 3-column window and 3-stage pipeline.
// Build option CONV_RELU_EN: unsigned ReLU saturation instead of signed saturation.
module conv3x3_column_pe
  import conv_pe_pkg::*;
#(
  parameter int unsigned N_COLS    = 34,
  parameter int unsigned COL_PIX   = 26,
  parameter int unsigned OUT_SHIFT = 4
) (
  input  logic                          PEclk,
  input  logic                          rst_n,
  input  logic [COL_PIX*PIX_W-1:0]      i_col_data,
  input  logic                          i_col_vld,
  input  logic                          i_w_wr,
  input  logic [3:0]                    i_w_addr,
  input  logic [W_W-1:0]                i_w_data,
  output logic [(COL_PIX-2)*PIX_W-1:0]  o_res_data,
  output logic                          o_res_vld,
  output logic [4:0]                    o_col_idx,
  output logic                          o_frame_done,
  output logic                          o_err,
  output logic                          o_busy
);

  localparam int unsigned N_RES = COL_PIX - 2;
  localparam int unsigned COL_W = COL_PIX * PIX_W;
  localparam int unsigned RES_W = N_RES * PIX_W;
  localparam int unsigned CNT_W = $clog2(N_COLS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_COLS);

`ifdef CONV_RELU_EN
  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(255);
`else
  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(127);
  localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(-128);
`endif

  pe_state_e        state_q, state_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic             drain_last_q, drain_last_d;

  logic             shift_en, launch, load_w, end_tok, end_err;
  logic [4:0]       launch_idx;

  logic [2:0][COL_W-1:0]        win_q;
  logic [N_TAPS-1:0][W_W-1:0]   wsh_q;
  logic [N_TAPS-1:0][W_W-1:0]   wact_q;

  logic       v1_q, last1_q, err1_q;
  logic [4:0] idx1_q;
  logic       v2_q, last2_q, err2_q;
  logic [4:0] idx2_q;

  logic [N_RES-1:0][N_TAPS-1:0][PIX_W-1:0] tap_pix;
  logic [N_RES-1:0][SUM_W-1:0]             mac_sum;
  logic [RES_W-1:0]                        res_d;
  logic signed [SUM_W-1:0]                 sh;
  logic [PIX_W-1:0]                        q;

  always_comb begin
    state_d      = state_q;
    in_cnt_d     = in_cnt_q;
    drain_last_d = drain_last_q;
    shift_en     = 1'b0;
    launch       = 1'b0;
    load_w       = 1'b0;
    end_tok      = 1'b0;
    end_err      = 1'b0;
    launch_idx   = 5'(in_cnt_q - CNT_W'(2));
    unique case (state_q)
      ST_IDLE: begin
        if (i_col_vld) begin
          shift_en = 1'b1;
          load_w   = 1'b1;
          in_cnt_d = CNT_W'(1);
          state_d  = ST_FILL;
        end
      end
      ST_FILL: begin
        if (i_col_vld) begin
          shift_en = 1'b1;
          in_cnt_d = in_cnt_q + 1'b1;
          state_d  = ST_RUN;
        end else begin
          end_tok      = 1'b1;
          end_err      = 1'b1;
          drain_last_d = 1'b0;
          state_d      = ST_DRAIN;
        end
      end
      ST_RUN: begin
        if (i_col_vld) begin
          shift_en = 1'b1;
          launch   = 1'b1;
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_d == LAST_CNT) begin
            end_tok      = 1'b1;
            drain_last_d = 1'b0;
            state_d      = ST_DRAIN;
          end
        end else begin
          end_tok      = 1'b1;
          end_err      = 1'b1;
          drain_last_d = 1'b0;
          state_d      = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!drain_last_q) begin
          drain_last_d = 1'b1;
        end else if (i_col_vld) begin
          shift_en = 1'b1;
          load_w   = 1'b1;
          in_cnt_d = CNT_W'(1);
          state_d  = ST_FILL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PEclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      in_cnt_q     <= '0;
      drain_last_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_cnt_q     <= in_cnt_d;
      drain_last_q <= drain_last_d;
    end
  end

  // Window index 0 is the oldest column; new columns enter at index 2.
  always_ff @(posedge PEclk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
    end else if (shift_en) begin
      win_q <= {i_col_data, win_q[2], win_q[1]};
    end
  end

  always_ff @(posedge PEclk or negedge rst_n) begin
    if (!rst_n) begin
      wsh_q  <= '0;
      wact_q <= '0;
    end else begin
      if (i_w_wr && (i_w_addr < 4'd9)) begin
        wsh_q[i_w_addr] <= i_w_data;
      end
      if (load_w) begin
        wact_q <= wsh_q;
      end
    end
  end

  // The end token rides the pipeline so o_err/o_frame_done line up behind in-flight results.
  always_ff @(posedge PEclk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      err1_q  <= 1'b0;
      idx1_q  <= '0;
      v2_q    <= 1'b0;
      last2_q <= 1'b0;
      err2_q  <= 1'b0;
      idx2_q  <= '0;
    end else begin
      v1_q    <= launch;
      last1_q <= end_tok;
      err1_q  <= end_err;
      idx1_q  <= launch_idx;
      v2_q    <= v1_q;
      last2_q <= last1_q;
      err2_q  <= err1_q;
      idx2_q  <= idx1_q;
    end
  end

  for (genvar j = 0; j < N_RES; j++) begin : g_res
    for (genvar r = 0; r < 3; r++) begin : g_r
      for (genvar c = 0; c < 3; c++) begin : g_c
        assign tap_pix[j][3*r+c] = win_q[c][pix_msb(COL_W, j + r) -: PIX_W];
      end
    end
    pe_mac9 u_mac (
      .PEclk (PEclk),
      .rst_n (rst_n),
      .en_i  (v1_q),
      .pix_i (tap_pix[j]),
      .wgt_i (wact_q),
      .sum_o (mac_sum[j])
    );
  end

  always_comb begin
    res_d = '0;
    sh    = '0;
    q     = '0;
    for (int unsigned j = 0; j < N_RES; j++) begin
      sh = $signed(mac_sum[j]) >>> OUT_SHIFT;
`ifdef CONV_RELU_EN
      if (sh[SUM_W-1]) begin
        q = '0;
      end else if (sh > SAT_HI) begin
        q = '1;
      end else begin
        q = sh[PIX_W-1:0];
      end
`else
      if (sh < SAT_LO) begin
        q = 8'h80;
      end else if (sh > SAT_HI) begin
        q = 8'h7F;
      end else begin
        q = sh[PIX_W-1:0];
      end
`endif
      res_d[pix_msb(RES_W, j) -: PIX_W] = q;
    end
  end

  always_ff @(posedge PEclk or negedge rst_n) begin
    if (!rst_n) begin
      o_res_data   <= '0;
      o_res_vld    <= 1'b0;
      o_col_idx    <= '0;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_res_vld    <= v2_q;
      o_frame_done <= last2_q & ~err2_q;
      o_err        <= last2_q & err2_q;
      if (v2_q) begin
        o_res_data <= res_d;
        o_col_idx  <= idx2_q;
      end
    end
  end

  assign o_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_conv3x3_column_pe.sv
// Directed/random bench for conv3x3_column_pe against an arithmetic convolution model.
module tb_conv3x3_column_pe;

  localparam int NC = 34;
  localparam int CP = 26;
  localparam int NR = 24;
  localparam int SH = 4;

  logic         PEclk = 1'b0;
  logic         rst_n = 1'b0;
  logic [207:0] i_col_data;
  logic         i_col_vld;
  logic         i_w_wr;
  logic [3:0]   i_w_addr;
  logic [7:0]   i_w_data;
  logic [191:0] o_res_data;
  logic         o_res_vld;
  logic [4:0]   o_col_idx;
  logic         o_frame_done;
  logic         o_err;
  logic         o_busy;

  conv3x3_column_pe #(
    .N_COLS    (NC),
    .COL_PIX   (CP),
    .OUT_SHIFT (SH)
  ) dut (
    .PEclk        (PEclk),
    .rst_n        (rst_n),
    .i_col_data   (i_col_data),
    .i_col_vld    (i_col_vld),
    .i_w_wr       (i_w_wr),
    .i_w_addr     (i_w_addr),
    .i_w_data     (i_w_data),
    .o_res_data   (o_res_data),
    .o_res_vld    (o_res_vld),
    .o_col_idx    (o_col_idx),
    .o_frame_done (o_frame_done),
    .o_err        (o_err),
    .o_busy       (o_busy)
  );

  always #5 PEclk = ~PEclk;

  typedef struct packed {
    logic [4:0]   idx;
    logic [191:0] data;
    logic         done;
  } res_t;

  res_t exp_q[$];
  res_t got_q[$];
  int   got_err;
  int   got_done;
  int   checks;
  int   errors;
  int   frm[NC][CP];
  int   w_cur[9];
  int   w_new[9];

  always @(negedge PEclk) begin
    if (rst_n) begin
      if (o_res_vld) got_q.push_back('{idx: o_col_idx, data: o_res_data, done: o_frame_done});
      if (o_err) got_err++;
      if (o_frame_done) got_done++;
    end
  end

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] quant(int s);
    int v;
    v = s >>> SH;
`ifdef CONV_RELU_EN
    if (v < 0) v = 0;
    if (v > 255) v = 255;
`else
    if (v < -128) v = -128;
    if (v > 127) v = 127;
`endif
    return v[7:0];
  endfunction

  // Expected output column k uses input columns k..k+2; weight 3r+c pairs with column k+c, pixel j+r.
  task automatic push_expected(input int ncols);
    res_t r;
    int   s;
    for (int k = 0; k < ncols - 2; k++) begin
      r.idx  = 5'(k);
      r.done = (ncols == NC) && (k == NC - 3);
      r.data = '0;
      for (int j = 0; j < NR; j++) begin
        s = 0;
        for (int rr = 0; rr < 3; rr++)
          for (int c = 0; c < 3; c++)
            s += w_cur[3*rr+c] * frm[k+c][j+rr];
        r.data[191-8*j -: 8] = quant(s);
      end
      exp_q.push_back(r);
    end
  endtask

  task automatic write_w(input int addr, input int val);
    i_w_wr   = 1'b1;
    i_w_addr = 4'(addr);
    i_w_data = 8'(val);
    @(posedge PEclk); #1;
    i_w_wr   = 1'b0;
  endtask

  task automatic load_weights();
    for (int a = 0; a < 9; a++) write_w(a, w_cur[a]);
  endtask

  task automatic gen_frame(input int mode, input int val);
    for (int c = 0; c < NC; c++)
      for (int p = 0; p < CP; p++)
        frm[c][p] = (mode == 0) ? val : (mode == 1) ? c + 1 : int'($urandom_range(0, 255));
  endtask

  // Drives ncols columns; with wr_mid, writes w_new into the shadow bank during columns 5..13.
  task automatic drive_frame(input int ncols, input bit wr_mid);
    logic [207:0] v;
    for (int c = 0; c < ncols; c++) begin
      for (int p = 0; p < CP; p++) v[207-8*p -: 8] = 8'(frm[c][p]);
      i_col_data = v;
      i_col_vld  = 1'b1;
      if (wr_mid && c >= 5 && c < 14) begin
        i_w_wr   = 1'b1;
        i_w_addr = 4'(c - 5);
        i_w_data = 8'(w_new[c-5]);
      end else begin
        i_w_wr = 1'b0;
      end
      @(posedge PEclk); #1;
      if (c == 0) chk("busy_after_first_col", 192'(o_busy), 192'(1));
    end
    i_col_vld = 1'b0;
    i_w_wr    = 1'b0;
  endtask

  task automatic check_results(input string tag, input int exp_err, input int exp_done);
    int n;
    repeat (8) @(posedge PEclk);
    #1;
    chk({tag, " count"}, 192'(got_q.size()), 192'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s idx[%0d]", tag, i), 192'(got_q[i].idx), 192'(exp_q[i].idx));
      chk($sformatf("%s data[%0d]", tag, i), got_q[i].data, exp_q[i].data);
      chk($sformatf("%s done[%0d]", tag, i), 192'(got_q[i].done), 192'(exp_q[i].done));
    end
    chk({tag, " err_pulses"}, 192'(got_err), 192'(exp_err));
    chk({tag, " done_pulses"}, 192'(got_done), 192'(exp_done));
    chk({tag, " busy_idle"}, 192'(o_busy), 192'(0));
    got_q.delete();
    exp_q.delete();
    got_err  = 0;
    got_done = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, " res_data"}, o_res_data, '0);
    chk({tag, " res_vld"}, 192'(o_res_vld), 192'(0));
    chk({tag, " col_idx"}, 192'(o_col_idx), 192'(0));
    chk({tag, " frame_done"}, 192'(o_frame_done), 192'(0));
    chk({tag, " err"}, 192'(o_err), 192'(0));
    chk({tag, " busy"}, 192'(o_busy), 192'(0));
  endtask

  task automatic rand_weights(output int w[9]);
    for (int a = 0; a < 9; a++) w[a] = int'($urandom_range(0, 255)) - 128;
  endtask

  initial begin
    checks = 0; errors = 0; got_err = 0; got_done = 0;
    i_col_data = '0; i_col_vld = 1'b0; i_w_wr = 1'b0; i_w_addr = '0; i_w_data = '0;

    // Reset state
    repeat (3) @(posedge PEclk);
    #1;
    check_outputs_zero("reset");
    @(negedge PEclk);
    rst_n = 1'b1;
    @(posedge PEclk); #1;

    // Identity kernel, pixel = column+1: output column k is k+2 everywhere
    foreach (w_cur[a]) w_cur[a] = 0;
    w_cur[4] = 16;
    load_weights();
    gen_frame(1, 0);
    push_expected(NC);
    drive_frame(NC, 1'b0);
    repeat (6) @(posedge PEclk);
    #1;
    chk("ident col0 const", (got_q.size() > 0) ? got_q[0].data : '0, {24{8'd2}});
    chk("ident col31 const", (got_q.size() > 31) ? got_q[31].data : '0, {24{8'd33}});
    check_results("ident", 0, 1);

    // All weights 1, all pixels 255: 2295 >>> 4 = 143
    foreach (w_cur[a]) w_cur[a] = 1;
    load_weights();
    gen_frame(0, 255);
    push_expected(NC);
    drive_frame(NC, 1'b0);
    repeat (6) @(posedge PEclk);
    #1;
`ifdef CONV_RELU_EN
    chk("ones const", (got_q.size() > 0) ? got_q[0].data : '0, {24{8'd143}});
`else
    chk("ones const", (got_q.size() > 0) ? got_q[0].data : '0, {24{8'h7F}});
`endif
    check_results("ones", 0, 1);

    // All weights -128, all pixels 255: negative saturation
    foreach (w_cur[a]) w_cur[a] = -128;
    load_weights();
    gen_frame(0, 255);
    push_expected(NC);
    drive_frame(NC, 1'b0);
    repeat (6) @(posedge PEclk);
    #1;
`ifdef CONV_RELU_EN
    chk("neg const", (got_q.size() > 0) ? got_q[0].data : '0, {24{8'h00}});
`else
    chk("neg const", (got_q.size() > 0) ? got_q[0].data : '0, {24{8'h80}});
`endif
    check_results("neg", 0, 1);

    // Random weights and pixels; out-of-range addresses must not disturb the bank
    rand_weights(w_cur);
    load_weights();
    for (int a = 9; a < 16; a++) write_w(a, int'($urandom_range(0, 255)));
    gen_frame(2, 0);
    push_expected(NC);
    drive_frame(NC, 1'b0);
    check_results("rand", 0, 1);

    // Abort after 10 columns: 8 results, one o_err, no o_frame_done
    gen_frame(2, 0);
    push_expected(10);
    drive_frame(10, 1'b0);
    check_results("abort10", 1, 0);

    // Abort in FILL after a single column
    gen_frame(2, 0);
    push_expected(1);
    drive_frame(1, 1'b0);
    check_results("abort1", 1, 0);

    // Back-to-back frames; weights written mid frame 1 apply from frame 2
    rand_weights(w_new);
    gen_frame(2, 0);
    push_expected(NC);
    drive_frame(NC, 1'b1);
    @(posedge PEclk); #1;
    w_cur = w_new;
    gen_frame(2, 0);
    push_expected(NC);
    drive_frame(NC, 1'b0);
    check_results("b2b", 0, 2);

    // Reset during RUN at column 20
    gen_frame(2, 0);
    drive_frame(20, 1'b0);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    got_q.delete();
    exp_q.delete();
    got_err  = 0;
    got_done = 0;
    repeat (2) @(posedge PEclk);
    @(negedge PEclk);
    rst_n = 1'b1;
    @(posedge PEclk); #1;
    rand_weights(w_cur);
    load_weights();
    gen_frame(2, 0);
    push_expected(NC);
    drive_frame(NC, 1'b0);
    check_results("post_rst", 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
